// File: rtl/shutdown_sense_pkg.sv
// Shared state encoding and sizing helpers for the shutdown sense scanner.
package shutdown_sense_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE
  } scan_state_t;

  // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int hit_cnt_w(input int filter_count);
    return cnt_w(filter_count);
  endfunction

  function automatic int next_sel(input int sel, input int num_ch);
    return (sel == num_ch - 1) ? 0 : sel + 1;
  endfunction

endpackage

// File: rtl/shutdown_sense_ch_filter.sv
// Per-channel consecutive-hit filter and sticky fault latch.
module shutdown_sense_ch_filter
  import shutdown_sense_pkg::*;
#(
  parameter int FILTER_COUNT = 2
) (
  input  logic clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_sample,
  input  logic i_act,
  input  logic i_clear,
  output logic o_latched,
  output logic o_set
);

  localparam int HIT_W = hit_cnt_w(FILTER_COUNT);
  localparam logic [HIT_W-1:0] HIT_MAX = HIT_W'(FILTER_COUNT);

  logic [HIT_W-1:0] r_hit;
  logic [HIT_W-1:0] w_hit_nxt;
  logic             r_latched;
  logic             w_hit_full;

  always_comb begin
    w_hit_nxt = r_hit;
    if (i_sample) begin
      if (i_act) begin
        w_hit_nxt = (r_hit == HIT_MAX) ? HIT_MAX : r_hit + 1'b1;
      end else begin
        w_hit_nxt = '0;
      end
    end
  end

  assign w_hit_full = i_sample && i_act && (w_hit_nxt == HIT_MAX);
  // Only a genuine 0->1 transition counts as a new fault for first-fault capture.
  assign o_set      = w_hit_full && !i_clear && !r_latched;
  assign o_latched  = r_latched;

  always_ff @(posedge clk) begin
    if (i_rst || !i_en) begin
      r_hit     <= '0;
      r_latched <= 1'b0;
    end else if (i_clear) begin
      r_hit     <= '0;
      r_latched <= 1'b0;
    end else begin
      r_hit <= w_hit_nxt;
      if (w_hit_full) begin
        r_latched <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/shutdown_sense_scan.sv
// Shutdown sense mux scanner: select sequencing, settle timer, scan strobe, first-fault capture.
// state  | meaning
// IDLE   | reset/disabled, next enabled cycle starts channel 0
// SETTLE | select held, waiting SETTLE_CYCLES+1 cycles for the mux to settle
// SAMPLE | sense pin evaluated for the current channel, select advances
module shutdown_sense_scan
  import shutdown_sense_pkg::*;
#(
  parameter int NUM_CH        = 8,
  parameter int SEL_W         = $clog2(NUM_CH),
  parameter int SETTLE_CYCLES = 4,
  parameter int FILTER_COUNT  = 2,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shutdown_sense_en,
  input  logic              shutdown_sense_pin,
  input  logic [NUM_CH-1:0] shutdown_sense_clear,
  output logic [SEL_W-1:0]  shutdown_sense_sel,
  output logic [NUM_CH-1:0] shutdown_sense,
  output logic              scan_done,
  output logic              first_fault_valid,
  output logic [SEL_W-1:0]  first_fault_idx
);

  localparam int CNT_W = cnt_w(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES);
  localparam logic [SEL_W-1:0] LAST_CH     = SEL_W'(NUM_CH - 1);

  scan_state_t       r_state;
  scan_state_t       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic              r_scan_done;
  logic              r_ff_valid;
  logic [SEL_W-1:0]  r_ff_idx;
  logic              w_soft_rst;
  logic              w_sample;
  logic              w_act;
  logic [NUM_CH-1:0] w_strobe;
  logic [NUM_CH-1:0] w_set;
  logic [NUM_CH-1:0] w_latched;

  assign w_soft_rst = rst || !shutdown_sense_en;
  assign w_sample   = (r_state == SAMPLE);
  assign w_act      = shutdown_sense_pin ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (w_soft_rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel   <= w_sel_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_nxt   = r_sel;
    unique case (r_state)
      IDLE: begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = '0;
        w_sel_nxt   = '0;
      end
      SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_state_nxt = SAMPLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      SAMPLE: begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = '0;
        w_sel_nxt   = SEL_W'(next_sel(int'(r_sel), NUM_CH));
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign w_strobe[g] = w_sample && (r_sel == SEL_W'(g));

    shutdown_sense_ch_filter #(
      .FILTER_COUNT(FILTER_COUNT)
    ) u_filter (
      .clk      (clk),
      .i_rst    (rst),
      .i_en     (shutdown_sense_en),
      .i_sample (w_strobe[g]),
      .i_act    (w_act),
      .i_clear  (shutdown_sense_clear[g]),
      .o_latched(w_latched[g]),
      .o_set    (w_set[g])
    );
  end

  always_ff @(posedge clk) begin
    if (w_soft_rst) begin
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= w_sample && (r_sel == LAST_CH);
    end
  end

  // Only the sampled channel can set in a cycle, so the current select is the fault index.
  always_ff @(posedge clk) begin
    if (w_soft_rst) begin
      r_ff_valid <= 1'b0;
      r_ff_idx   <= '0;
    end else if (r_ff_valid) begin
      if (shutdown_sense_clear[r_ff_idx]) begin
        r_ff_valid <= 1'b0;
      end
    end else if (|w_set) begin
      r_ff_valid <= 1'b1;
      r_ff_idx   <= r_sel;
    end
  end

  assign shutdown_sense_sel = r_sel;
  assign shutdown_sense     = w_latched;
  assign scan_done          = r_scan_done;
  assign first_fault_valid  = r_ff_valid;
  assign first_fault_idx    = r_ff_idx;

endmodule

// File: tb/tb_shutdown_sense_scan.sv
// Directed bench: 8-channel active-high scanner plus a 5-channel active-low variant.
module tb_shutdown_sense_scan;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic       rst_a, en_a, pin_a;
  logic [7:0] clear_a, sense_a;
  logic [2:0] sel_a, idx_a;
  logic       done_a, ffv_a;
  logic [7:0] mask_a, clr_req_a, exp_sense;

  logic       rst_5, en_5, pin_5;
  logic [4:0] clear_5, sense_5, mask_5;
  logic [2:0] sel_5, idx_5;
  logic       done_5, ffv_5;

  shutdown_sense_scan #(
    .NUM_CH(8), .SEL_W(3), .SETTLE_CYCLES(4), .FILTER_COUNT(2), .ACTIVE_LOW(1'b0)
  ) u_dut_a (
    .clk                 (clk),
    .rst                 (rst_a),
    .shutdown_sense_en   (en_a),
    .shutdown_sense_pin  (pin_a),
    .shutdown_sense_clear(clear_a),
    .shutdown_sense_sel  (sel_a),
    .shutdown_sense      (sense_a),
    .scan_done           (done_a),
    .first_fault_valid   (ffv_a),
    .first_fault_idx     (idx_a)
  );

  shutdown_sense_scan #(
    .NUM_CH(5), .SEL_W(3), .SETTLE_CYCLES(0), .FILTER_COUNT(1), .ACTIVE_LOW(1'b1)
  ) u_dut_5 (
    .clk                 (clk),
    .rst                 (rst_5),
    .shutdown_sense_en   (en_5),
    .shutdown_sense_pin  (pin_5),
    .shutdown_sense_clear(clear_5),
    .shutdown_sense_sel  (sel_5),
    .shutdown_sense      (sense_5),
    .scan_done           (done_5),
    .first_fault_valid   (ffv_5),
    .first_fault_idx     (idx_5)
  );

  // Inputs chosen in one iteration are applied just after the edge, so they act on the next edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    pin_a   = mask_a[sel_a];
    clear_a = clr_req_a;
    pin_5   = ~mask_5[sel_5];
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b0; pin_a = 1'b0; clear_a = '0; mask_a = '0; clr_req_a = '0;
    rst_5 = 1'b1; en_5 = 1'b0; pin_5 = 1'b1; clear_5 = '0; mask_5 = '0;
    cyc();
    cyc();
    check("rst_sel", sel_a, 0);
    check("rst_sense", sense_a, 0);
    check("rst_done", done_a, 0);
    check("rst_ffv", ffv_a, 0);
    check("rst_idx", idx_a, 0);
    check("rst_sel5", sel_5, 0);
    check("rst_sense5", sense_5, 0);

    // Disabled with the pin at the fault level: nothing may move.
    rst_a = 1'b0; rst_5 = 1'b0; mask_a = 8'hFF;
    for (int t = 0; t < 10; t++) begin
      cyc();
      check("dis_sel", sel_a, 0);
      check("dis_sense", sense_a, 0);
      check("dis_done", done_a, 0);
    end

    // Scan timing with every channel active: 6 cycles per channel, 48 per pass.
    en_a = 1'b1;
    for (int t = 0; t < 132; t++) begin
      cyc();
      exp_sense = '0;
      for (int c = 0; c < 8; c++) begin
        if (t >= 48 + 6 * (c + 1)) exp_sense[c] = 1'b1;
      end
      check("scan_sel", sel_a, (t / 6) % 8);
      check("scan_done", done_a, (t % 48 == 0) && (t > 0));
      check("scan_sense", sense_a, exp_sense);
      check("scan_ffv", ffv_a, t >= 54);
      check("scan_idx", idx_a, 0);
    end
    check("mid_sel5", sel_a, 5);
    rst_a = 1'b1;
    cyc();
    check("midrst_sel", sel_a, 0);
    check("midrst_sense", sense_a, 0);
    check("midrst_done", done_a, 0);
    check("midrst_ffv", ffv_a, 0);
    check("midrst_idx", idx_a, 0);
    rst_a = 1'b0; en_a = 1'b0; mask_a = '0;
    cyc();

    // Filter on channel 3, then clear colliding with a re-latch, then re-latch.
    mask_a = 8'h08; en_a = 1'b1;
    for (int t = 0; t < 217; t++) begin
      clr_req_a = (t == 119) ? 8'h08 : 8'h00;
      cyc();
      case (t)
        48:  begin check("flt_p1_sense", sense_a, 8'h00); check("flt_p1_done", done_a, 1); end
        71:  check("flt_pre_latch", sense_a, 8'h00);
        72:  begin
               check("flt_latch", sense_a, 8'h08);
               check("flt_ffv", ffv_a, 1);
               check("flt_idx", idx_a, 3);
             end
        96:  check("flt_p2_sense", sense_a, 8'h08);
        119: check("clr_pre", sense_a, 8'h08);
        120: begin check("clr_sense", sense_a, 8'h00); check("clr_ffv", ffv_a, 0); end
        168: check("relatch_p4", sense_a, 8'h00);
        215: check("relatch_pre", sense_a, 8'h00);
        216: begin
               check("relatch_sense", sense_a, 8'h08);
               check("relatch_ffv", ffv_a, 1);
               check("relatch_idx", idx_a, 3);
             end
        default: ;
      endcase
    end
    check("dis_mid_sel_pre", sel_a, 4);
    en_a = 1'b0;
    cyc();
    check("dis_mid_sel", sel_a, 0);
    check("dis_mid_sense", sense_a, 0);
    check("dis_mid_ffv", ffv_a, 0);

    // Active, inactive, active: the counter must restart so nothing latches.
    en_a = 1'b1;
    for (int t = 0; t < 144; t++) begin
      mask_a = (t / 48 == 1) ? 8'h00 : 8'h08;
      cyc();
      if (t == 72)  check("brk_p2", sense_a, 8'h00);
      if (t == 120) check("brk_p3", sense_a, 8'h00);
      if (t == 143) begin check("brk_end", sense_a, 8'h00); check("brk_ffv", ffv_a, 0); end
    end
    en_a = 1'b0;
    cyc();

    // First-fault retention: ch2 latches first, then ch6.
    en_a = 1'b1;
    for (int t = 0; t < 148; t++) begin
      mask_a    = (t >= 144) ? 8'h00 : (8'h04 | ((t >= 48) ? 8'h40 : 8'h00));
      clr_req_a = (t == 144) ? 8'h40 : ((t == 146) ? 8'h04 : 8'h00);
      cyc();
      if (t == 65) check("ff_pre", sense_a, 8'h00);
      if (t == 66) begin
        check("ff_ch2_sense", sense_a, 8'h04);
        check("ff_ch2_ffv", ffv_a, 1);
        check("ff_ch2_idx", idx_a, 2);
      end
      if (t == 137) check("ff_ch6_pre", sense_a, 8'h04);
      if (t == 143) begin
        check("ff_both_sense", sense_a, 8'h44);
        check("ff_both_idx", idx_a, 2);
        check("ff_both_ffv", ffv_a, 1);
      end
      if (t == 145) begin
        check("ff_clr6_sense", sense_a, 8'h04);
        check("ff_clr6_idx", idx_a, 2);
        check("ff_clr6_ffv", ffv_a, 1);
      end
      if (t == 147) begin
        check("ff_clr2_sense", sense_a, 8'h00);
        check("ff_clr2_ffv", ffv_a, 0);
      end
    end
    en_a = 1'b0;
    cyc();

    // Five channels, no settle, single-sample filter, active-low pin on channel 4.
    en_5 = 1'b1; mask_5 = 5'b10000;
    for (int t = 0; t < 25; t++) begin
      cyc();
      check("n5_sel", sel_5, (t / 2) % 5);
      check("n5_done", done_5, (t % 10 == 0) && (t > 0));
      check("n5_sense", sense_5, (t >= 10) ? 5'b10000 : 5'b00000);
      check("n5_ffv", ffv_5, t >= 10);
      if (t >= 10) check("n5_idx", idx_5, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/shutdown_sense_scan.md
Name: shutdown_sense_scan

Overview:
- Parametrised successor to the 8-channel shutdown sense scanner.
- Drives an external analog mux select, waits a programmable settle time, then samples the shared sense pin.
- Requires FILTER_COUNT consecutive active samples per channel before latching a sticky fault.
- Adds per-channel clear, scan-complete strobe and first-fault capture. Sits between the LCB shutdown mux pins and the status/interlock register block.

Parameters:
- NUM_CH, 8, number of mux channels (2..64, need not be a power of two).
- SEL_W, $clog2(NUM_CH), width of the mux select output.
- SETTLE_CYCLES, 4, cycles held on a new select before sampling (0 allowed).
- FILTER_COUNT, 2, consecutive active samples needed to latch a channel (1..15).
- ACTIVE_LOW, 0, 1 means pin low is the fault level.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- shutdown_sense_en  in  1  scan enable; low behaves as a soft reset of all state
- shutdown_sense_pin  in  1  shared mux output, already synchronised upstream
- shutdown_sense_clear  in  NUM_CH  per-channel clear of the latched fault and filter counter
- shutdown_sense_sel  out  SEL_W  mux select
- shutdown_sense  out  NUM_CH  sticky latched faults
- scan_done  out  1  one-cycle pulse on completion of each full pass
- first_fault_valid  out  1  a first fault has been captured
- first_fault_idx  out  SEL_W  index of the first channel to latch

Behaviour:
- rst=1, or shutdown_sense_en=0, at a clock edge:
  - sel=0, shutdown_sense=0, scan_done=0, first_fault_valid=0, first_fault_idx=0.
  - All hit counters=0, settle counter=0, state=IDLE.
  - rst has priority over everything else.
- State machine: IDLE -> SETTLE -> SAMPLE -> SETTLE ...
  - IDLE: entered on reset/disable. Moves to SETTLE on the first enabled cycle, with sel=0 and settle count=0.
  - SETTLE: increments the settle count. Moves to SAMPLE on the cycle the count reaches SETTLE_CYCLES. With SETTLE_CYCLES=0, SETTLE lasts 1 cycle.
  - SAMPLE (1 cycle):
    - act = pin XOR ACTIVE_LOW.
    - act=1: hit_cnt[sel] increments, saturating at FILTER_COUNT. If the new value equals FILTER_COUNT, set shutdown_sense[sel]=1.
    - act=0: hit_cnt[sel]=0. A latched bit stays set.
    - sel advances: NUM_CH-1 wraps to 0, otherwise sel+1. Settle count resets to 0. Return to SETTLE.
- Per-channel period is SETTLE_CYCLES+2 cycles. A full pass takes NUM_CH*(SETTLE_CYCLES+2) cycles.
- scan_done is registered. It is high for exactly the cycle after the SAMPLE of channel NUM_CH-1.
- Filter counter persistence: hit counters persist across passes. FILTER_COUNT=2 therefore means two consecutive passes active on that channel.
- Clear:
  - shutdown_sense_clear[i]=1 zeroes shutdown_sense[i] and hit_cnt[i] that cycle.
  - Clear wins over a simultaneous set on the same channel.
  - Clear does not alter sel or the scan timing.
- First fault:
  - Captured on the cycle a bit sets while first_fault_valid=0: first_fault_idx=sel, valid=1.
  - Only one channel can set per cycle, so there is no tie to resolve.
  - Valid clears when shutdown_sense_clear[first_fault_idx]=1.
  - A set and that clear in the same cycle: the clear wins and valid stays 0.
- Enable dropped mid-scan: full soft reset, as above. Re-enable restarts at channel 0 with a full settle.
- Outputs update only on clk edges; there are no combinational paths from inputs to outputs.

Decomposition:
- Package shutdown_sense_pkg:
  - state enum scan_state_t {IDLE, SETTLE, SAMPLE}.
  - Width constant for the hit counter: $clog2(FILTER_COUNT+1).
  - Helper function next_sel(sel, NUM_CH) implementing the wrap.
- Sub-module shutdown_sense_ch_filter: one per channel via generate. Holds hit_cnt and the latched bit. Inputs are sample strobe, act, clear, en, rst.
- Top level: FSM, settle counter, select, scan_done, first-fault logic.

Test Plan:
- Reset/disable: NUM_CH=8, SETTLE=4. Hold en=0 for 10 cycles with pin=1 -> sel=0, sense=0x00, scan_done never high. Assert rst mid-scan at sel=5 -> everything 0 on the next cycle.
- Scan timing: en=1, pin=0 -> sel steps 0..7 every 6 cycles, wraps to 0. scan_done pulses once per 48 cycles, on the cycle after channel 7's sample.
- Filter: pin=1 only while sel=3, FILTER_COUNT=2.
  - After pass 1, sense=0x00.
  - After pass 2, sense=0x08, first_fault_valid=1, idx=3.
  - Pin active on pass 1, inactive on pass 2, active on pass 3 -> still 0x00 after pass 3.
- Clear priority: with sense=0x08, pulse clear=0x08 on the same cycle channel 3 would latch again -> sense=0x00 and first_fault_valid=0. Channel 3 re-latches after two more active passes.
- Non-power-of-two and polarity: NUM_CH=5, SETTLE_CYCLES=0, FILTER_COUNT=1, ACTIVE_LOW=1. Pin low only while sel=4 -> sel wraps 4->0, period 2 cycles/channel. sense=5'b10000 after one pass, idx=4.
- First-fault retention: latch ch2, then ch6 -> sense=0x44, idx stays 2. Clear bit 6 -> idx remains 2, valid=1. Clear bit 2 -> valid=0.
